// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the MEM stage: load/store funct3 codes, writeback
// result-source selects and the data-memory access FSM state.
package riscv_mem_pkg;

    localparam int MEM_XLEN = 32;

    // Load funct3 encodings; bits [1:0] give the access size
    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] ST_SB = 3'b000;
    localparam logic [2:0] ST_SH = 3'b001;
    localparam logic [2:0] ST_SW = 3'b010;

    // Access sizes as carried in funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Writeback result source
    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;

    // Data-memory access FSM
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for the MEM stage: store byte enables and lane
// replication, load lane extraction with sign/zero extension, and
// misaligned-access detection (only when MEM_MISALIGN_TRAP_EN is defined;
// otherwise offset bits below the access size are simply ignored).
module load_store_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic [2:0]  load_type_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] byte_lane;
    logic [31:0] half_lane;

    // Store side: byte enables follow the offset, data is replicated on all lanes
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << {offset_i[1], 1'b0};
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: shift the addressed lane down, then extend per funct3
    always_comb begin
        byte_lane = load_data_i >> {offset_i, 3'b000};
        half_lane = load_data_i >> {offset_i[1], 4'b0000};
        case (load_type_i)
            LT_LB:   rdata_o = {{24{byte_lane[7]}}, byte_lane[7:0]};
            LT_LH:   rdata_o = {{16{half_lane[15]}}, half_lane[15:0]};
            LT_LBU:  rdata_o = {24'h000000, byte_lane[7:0]};
            LT_LHU:  rdata_o = {16'h0000, half_lane[15:0]};
            default: rdata_o = load_data_i;
        endcase
    end

    // Misalignment: halfwords need addr[0]=0, words need addr[1:0]=00
    always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
        case (size_i)
            SZ_HALF: misalign_o = offset_i[0];
            SZ_WORD: misalign_o = |offset_i;
            default: misalign_o = 1'b0;
        endcase
`else
        misalign_o = 1'b0;
`endif
    end

endmodule

// File: rtl/memory_access_cycle.sv
// MEM stage of the RV32IM pipeline. Issues loads/stores on a ready/valid
// data-memory port, stalls the front of the pipe while an access is in
// flight, and drives the MEM/WB register. Optional MEM_MISALIGN_TRAP_EN
// suppresses misaligned accesses and flags them in MisalignW.
//
// Handshake: a request is presented while dmem_req=1 and is accepted in the
// cycle dmem_gnt=1 (gnt is ignored while dmem_req=0). A granted load then
// waits in RESP for dmem_rvalid, which is ignored in any other state.
module memory_access_cycle
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = MEM_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [4:0]      RD_M,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [2:0]      LoadTypeM,
    input  logic [2:0]      StoreTypeM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            StallM,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [4:0]      RD_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic            MisalignW,
    output logic            fsm_state_o
);

    mem_state_e  state_q, state_d;
    logic        is_store, is_load, active;
    logic        misaligned;
    logic        complete;
    logic        load_done;
    logic [1:0]  size;
    logic [31:0] load_fmt;

    assign is_store = MemWriteM;
    assign is_load  = ~MemWriteM & (ResultSrcM == RS_LOAD);
    assign active   = is_store | is_load;
    // Reserved store encodings fall back to a full-word access
    assign size     = MemWriteM ? (StoreTypeM[2] ? SZ_WORD : StoreTypeM[1:0])
                                : LoadTypeM[1:0];

    load_store_align u_align (
        .offset_i     (ALU_ResultM[1:0]),
        .size_i       (size),
        .load_type_i  (LoadTypeM),
        .store_data_i (WriteDataM),
        .load_data_i  (dmem_rdata),
        .be_o         (dmem_be),
        .wdata_o      (dmem_wdata),
        .rdata_o      (load_fmt),
        .misalign_o   (misaligned)
    );

    assign dmem_addr   = {ALU_ResultM[XLEN-1:2], 2'b00};
    assign dmem_we     = dmem_req & MemWriteM;
    assign StallM      = active & ~complete;
    assign fsm_state_o = state_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: a granted load waits for its response
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (is_load & ~misaligned & dmem_gnt) state_d = RESP;
            RESP: if (dmem_rvalid)                      state_d = IDLE;
            default:                                    state_d = IDLE;
        endcase
    end

    // FSM outputs: request, completion and load-data capture strobe
    always_comb begin
        dmem_req  = 1'b0;
        complete  = 1'b0;
        load_done = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_req = active & ~misaligned;
                complete = (active & misaligned) | (is_store & ~misaligned & dmem_gnt);
            end
            RESP: begin
                complete  = dmem_rvalid;
                load_done = dmem_rvalid;
            end
            default: ;
        endcase
    end

    // MEM/WB register: bubble while stalled, otherwise capture EX/MEM fields
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RD_W        <= 5'd0;
            PCPlus4W    <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            MisalignW   <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            RD_W      <= 5'd0;
            MisalignW <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM & ~(active & misaligned);
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            MisalignW   <= active & misaligned;
            if (load_done) ReadDataW <= load_fmt;
        end
    end

endmodule

// File: tb/tb_memory_access_cycle.sv
// Bench for memory_access_cycle: table of formatting vectors, directed
// corner sequences and randomized loads/stores against a reference model.
module tb_memory_access_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
  logic [2:0]  LoadTypeM, StoreTypeM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        StallM, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  logic        MisalignW;
  logic        fsm_state_o;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  memory_access_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .LoadTypeM(LoadTypeM), .StoreTypeM(StoreTypeM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .MisalignW(MisalignW), .fsm_state_o(fsm_state_o)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // reference: loaded value from a memory word, computed with plain arithmetic
  function automatic logic [31:0] ref_load(input logic [2:0] ty, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] v;
    int off;
    off = int'(addr % 4);
    case (ty)
      3'b000, 3'b100: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (ty == 3'b000 && v >= 128) v = v + 32'hFFFFFF00;
      end
      3'b001, 3'b101: begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (ty == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << (2 * (off / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d % 256) * 32'h01010101;
    if (sz == 2'd1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  task automatic set_nop();
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 2'b00; RD_M = 0;
    PCPlus4M = 0; ALU_ResultM = 0; WriteDataM = 0;
    LoadTypeM = 0; StoreTypeM = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  // One memory instruction, held in EX/MEM until it completes.
  // g = cycles before grant, r = cycles from grant to rvalid (loads).
  task automatic do_op(input logic st, input logic [2:0] ty, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rword,
                       input int g, input int r, input logic [4:0] rd);
    logic [1:0] sz;
    logic       mis;
    int         last;
    sz  = ty[1:0];
    mis = TRAP && ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00));
    last = mis ? 0 : (st ? g : g + r);
    if (!st && !mis) exp_q.push_back(ref_load(ty, addr, rword));
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      RegWriteM = !st; MemWriteM = st; ResultSrcM = st ? 2'b00 : 2'b01;
      RD_M = rd; ALU_ResultM = addr; PCPlus4M = addr + 4; WriteDataM = wd;
      LoadTypeM = ty; StoreTypeM = st ? ty : 3'b000;
      dmem_gnt    = !mis && (c == g);
      dmem_rvalid = !st && !mis && (c == g + r);
      dmem_rdata  = dmem_rvalid ? rword : 32'h5A5A0F0F;
      #1;
      chk("stall", 32'(StallM), 32'(c < last));
      chk("req", 32'(dmem_req), 32'(!mis && c <= g));
      if (c == 0 && !mis) begin
        chk("addr", dmem_addr, addr & 32'hFFFFFFFC);
        chk("be", 32'(dmem_be), 32'(ref_be(sz, addr)));
        chk("we", 32'(dmem_we), 32'(st));
        if (st) chk("wdata", dmem_wdata, ref_wdata(sz, wd));
      end
      @(posedge clk); #1;
      if (c < last) begin
        chk("bubble_regwrite", 32'(RegWriteW), 32'd0);
        chk("bubble_rd", 32'(RD_W), 32'd0);
      end else begin
        if (!st && !mis) last_rd = exp_q.pop_front();
        chk("w_regwrite", 32'(RegWriteW), 32'(!st && !mis));
        chk("w_misalign", 32'(MisalignW), 32'(mis));
        chk("w_rd", 32'(RD_W), 32'(rd));
        chk("w_alu", ALU_ResultW, addr);
        chk("w_pc4", PCPlus4W, addr + 4);
        chk("w_readdata", ReadDataW, last_rd);
      end
    end
    @(negedge clk);
    dmem_gnt = 0; dmem_rvalid = 0;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  ty;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5};
    vecs[2] = '{1'b1, 3'b000, 32'h101, 32'h12345678, 4'b0010, 32'h78787878};
    vecs[3] = '{1'b1, 3'b001, 32'h102, 32'hCAFE1234, 4'b1100, 32'h12341234};
    vecs[4] = '{1'b1, 3'b001, 32'h100, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF};
    vecs[5] = '{1'b0, 3'b000, 32'h102, 32'h00000000, 4'b0100, 32'h00000000};
    vecs[6] = '{1'b0, 3'b010, 32'h104, 32'h00000000, 4'b1111, 32'h00000000};
    vecs[7] = '{1'b0, 3'b101, 32'h106, 32'h00000000, 4'b1100, 32'h00000000};

    last_rd = 0;
    set_nop();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", 32'(RegWriteW), 0);
    chk("rst_readdata", ReadDataW, 0);
    chk("rst_alu", ALU_ResultW, 0);
    chk("rst_state", 32'(fsm_state_o), 0);
    @(negedge clk);
    rst = 0;

    // formatting table, no grant so the FSM stays idle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      MemWriteM = vecs[i].st; RegWriteM = !vecs[i].st;
      ResultSrcM = vecs[i].st ? 2'b00 : 2'b01;
      ALU_ResultM = vecs[i].addr; WriteDataM = vecs[i].wd;
      LoadTypeM = vecs[i].ty; StoreTypeM = vecs[i].st ? vecs[i].ty : 3'b000;
      dmem_gnt = 0;
      #1;
      chk("tbl_req", 32'(dmem_req), 1);
      chk("tbl_we", 32'(dmem_we), 32'(vecs[i].st));
      chk("tbl_addr", dmem_addr, vecs[i].addr & 32'hFFFFFFFC);
      chk("tbl_be", 32'(dmem_be), 32'(vecs[i].exp_be));
      chk("tbl_wdata", dmem_wdata, vecs[i].exp_wdata);
      chk("tbl_stall", 32'(StallM), 1);
    end
    @(negedge clk);
    set_nop();

    // zero-wait stores
    do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 5'd3);
    do_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 5'd4);
    // LB / LBU with grant at 0, rvalid two cycles later
    do_op(1'b0, 3'b000, 32'h102, 0, 32'h0080FF00, 0, 2, 5'd5);
    do_op(1'b0, 3'b100, 32'h102, 0, 32'h0080FF00, 0, 2, 5'd6);
    // misaligned word load (trapped or offset-ignored)
    do_op(1'b0, 3'b010, 32'h102, 0, 32'h11223344, 1, 1, 5'd8);

    // ADD right behind a stalled load
    do_op(1'b0, 3'b001, 32'h302, 0, 32'h9ABC0000, 1, 1, 5'd9);
    RegWriteM = 1; MemWriteM = 0; ResultSrcM = 2'b00; RD_M = 5'd7;
    ALU_ResultM = 32'h1234; PCPlus4M = 32'h40;
    #1;
    chk("add_stall", 32'(StallM), 0);
    chk("add_req", 32'(dmem_req), 0);
    @(posedge clk); #1;
    chk("add_regwrite", 32'(RegWriteW), 1);
    chk("add_rd", 32'(RD_W), 7);
    chk("add_alu", ALU_ResultW, 32'h1234);
    chk("add_src", 32'(ResultSrcW), 0);
    chk("add_readdata_hold", ReadDataW, last_rd);

    // reset while waiting for a load response, then a stray rvalid
    @(negedge clk);
    set_nop();
    RegWriteM = 1; ResultSrcM = 2'b01; RD_M = 5'd10; ALU_ResultM = 32'h200;
    LoadTypeM = 3'b010; dmem_gnt = 1;
    @(posedge clk); #1;
    chk("resp_state", 32'(fsm_state_o), 1);
    @(negedge clk);
    dmem_gnt = 0; rst = 1;
    @(posedge clk); #1;
    chk("rstm_state", 32'(fsm_state_o), 0);
    chk("rstm_regwrite", 32'(RegWriteW), 0);
    chk("rstm_rd", 32'(RD_W), 0);
    chk("rstm_readdata", ReadDataW, 0);
    chk("rstm_alu", ALU_ResultW, 0);
    chk("rstm_pc4", PCPlus4W, 0);
    chk("rstm_src", 32'(ResultSrcW), 0);
    chk("rstm_misalign", 32'(MisalignW), 0);
    @(negedge clk);
    rst = 0; set_nop(); last_rd = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("stray_stall", 32'(StallM), 0);
    chk("stray_req", 32'(dmem_req), 0);
    @(posedge clk); #1;
    chk("stray_readdata", ReadDataW, 0);
    chk("stray_state", 32'(fsm_state_o), 0);
    @(negedge clk);
    set_nop();

    // randomized loads and stores
    for (int n = 0; n < 60; n++) begin
      logic st;
      logic [2:0] ty;
      logic [2:0] ltypes[5];
      ltypes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      st = 1'($urandom_range(0, 1));
      ty = st ? 3'($urandom_range(0, 2)) : ltypes[$urandom_range(0, 4)];
      do_op(st, ty, 32'h200 + 32'($urandom_range(0, 63)), $urandom, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
            5'($urandom_range(1, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_access_cycle.md
# memory_access_cycle

MEM stage of the RV32IM 5-stage pipeline: consumes the EX/MEM register fields, runs loads and stores on a ready/valid data-memory port, formats byte/half/word data, and drives the MEM/WB pipeline register. It sits between the execute stage and the writeback stage. It raises a stall request upstream whenever the data memory is slower than one cycle.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- RegWriteM, MemWriteM  in  1 each  EX/MEM control.
- ResultSrcM  in  2  00 = ALU, 01 = load data, 10 = PC+4. 01 marks a load.
- RD_M  in  5  destination register.
- PCPlus4M, ALU_ResultM, WriteDataM  in  XLEN each  EX/MEM data. ALU_ResultM is the effective address.
- LoadTypeM  in  3  funct3 encoding: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- StoreTypeM  in  3  SB 000, SH 001, SW 010.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  word-aligned address, {ALU_ResultM[31:2], 2'b00}.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  load data.
- StallM  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- RegWriteW  out  1  MEM/WB register.
- ResultSrcW  out  2  MEM/WB register.
- RD_W  out  5  MEM/WB register.
- PCPlus4W, ALU_ResultW, ReadDataW  out  XLEN each  MEM/WB register.
- MisalignW  out  1  MEM/WB register; misaligned-access flag.

## Operation
- An access is active when MemWriteM=1 or ResultSrcM=01.
- FSM states:
  - IDLE: dmem_req = active & ~misaligned.
    - Store with gnt: complete.
    - Load with gnt: go to RESP.
    - No gnt: stay in IDLE, holding the request.
  - RESP: dmem_req=0. rvalid completes the load and returns to IDLE.
- StallM = active & ~complete_this_cycle.
- Non-memory instructions never stall.
- Store formatting:
  - SB: be = 0001 << addr[1:0], wdata = {4{WriteDataM[7:0]}}.
  - SH: be = 0011 << {addr[1],1'b0}, wdata = {2{WriteDataM[15:0]}}.
  - SW: be = 1111.
- Load formatting: select the lane of dmem_rdata by addr[1:0]. Sign-extend LB/LH; zero-extend LBU/LHU.
- MEM/WB register updates every cycle:
  - Stalled cycle: write a bubble (RegWriteW=0, RD_W=0, MisalignW=0); data fields hold.
  - Otherwise: capture all fields. ReadDataW takes the formatted rdata on load completion and holds otherwise.
- dmem_rvalid is ignored outside RESP.
- dmem_gnt is ignored when dmem_req=0.

## Timing
- Reset: every output register clears to 0 and the FSM goes to IDLE. Reset mid-access abandons the transaction; a late rvalid after reset is ignored.
- Zero-wait store (gnt in the first cycle): no stall. The W fields update at the next edge.
- Load: minimum 1 stall cycle (gnt, then rvalid in the next cycle). With the grant after g cycles and the response after r further cycles, the stall lasts g+r cycles.
- Back-to-back memory operations: the next request can assert in the cycle after completion.
- Address and data inputs must stay stable while StallM=1, because EX/MEM is frozen.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access is detected: halfword with addr[0]=1, or word with addr[1:0]≠00.
  - No dmem_req is issued and there is no stall.
  - The W stage gets MisalignW=1 and RegWriteW=0.
- Undefined:
  - Offset bits below the access size are ignored. SH uses addr[1]; SW/LW use offset 0.
  - MisalignW is tied to 0.

## Structure
- Package riscv_mem_pkg holds:
  - LoadType and StoreType encodings.
  - ResultSrc encodings.
  - The FSM state enum (IDLE, RESP).
- One sub-module, load_store_align: combinational byte-enable/wdata generation and load extraction/extension.

## Test plan
- SW 0xDEADBEEF to 0x100, gnt in the same cycle -> dmem_be=1111, dmem_wdata=0xDEADBEEF, StallM never high, RegWriteW=0.
- SB 0x000000A5 to 0x103 -> be=1000, wdata=0xA5A5A5A5.
- LB at 0x102, gnt at cycle 0, rvalid at cycle 2 with rdata 0x0080FF00 -> 2 stall cycles with bubbles, then ReadDataW=0xFFFFFF80. The same access as LBU -> 0x00000080.
- Load in RESP, rst asserted, then a stray rvalid -> all outputs 0, FSM in IDLE, rvalid ignored.
- With MEM_MISALIGN_TRAP_EN: LW at 0x102 -> no dmem_req, MisalignW=1, RegWriteW=0. Without it: a request to 0x100 with be=1111.
- ADD (ResultSrcM=00) after a stalled load -> the ADD stays frozen in EX/MEM until the load completes, then appears in W one cycle after the load.
